// File: rtl/serializer.sv
// Parallel-to-serial converter: shifts out N bits of a word, one per clock, MSB first.
// Define SERIALIZER_LSB_FIRST_EN to send LSB first instead.
module serializer #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [MOD_W:0]    cnt_q, cnt_d;
    logic              ser_q, ser_d;
    logic              val_q, val_d;
    logic              busy_q, busy_d;

    logic [MOD_W:0]    n_bits;
    logic              accept;
    logic              load_bit;
    logic [DATA_W-1:0] load_rest;
    logic              next_bit;
    logic [DATA_W-1:0] next_rest;

    assign n_bits = (data_mod_i == '0) ? (MOD_W+1)'(DATA_W) : {1'b0, data_mod_i};
    assign accept = data_val_i && !busy_q && (n_bits >= (MOD_W+1)'(3));

`ifdef SERIALIZER_LSB_FIRST_EN
    assign load_bit  = data_i[0];
    assign load_rest = data_i >> 1;
    assign next_bit  = shreg_q[0];
    assign next_rest = shreg_q >> 1;
`else
    assign load_bit  = data_i[DATA_W-1];
    assign load_rest = data_i << 1;
    assign next_bit  = shreg_q[DATA_W-1];
    assign next_rest = shreg_q << 1;
`endif

    // The first bit goes straight to the output register at acceptance, so
    // cnt_q counts the bits still queued behind the one currently on the line.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ser_d   = 1'b0;
        val_d   = 1'b0;
        busy_d  = 1'b0;
        if (accept) begin
            state_d = ST_SEND;
            ser_d   = load_bit;
            shreg_d = load_rest;
            cnt_d   = n_bits - (MOD_W+1)'(1);
            val_d   = 1'b1;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ST_SEND: begin
                    if (cnt_q != '0) begin
                        ser_d   = next_bit;
                        shreg_d = next_rest;
                        cnt_d   = cnt_q - (MOD_W+1)'(1);
                        val_d   = 1'b1;
                        busy_d  = (cnt_q != (MOD_W+1)'(1));
                    end else begin
                        state_d = ST_IDLE;
                        shreg_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
        end
    end

    assign ser_data_o     = ser_q;
    assign ser_data_val_o = val_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench for serializer: driver pushes per-cycle expected bits, monitor checks outputs.
module tb_serializer;

    localparam int DATA_W = 16;
    localparam int MOD_W  = 4;

    logic              clk = 1'b0;
    logic              srst;
    logic [DATA_W-1:0] din;
    logic [MOD_W-1:0]  dmod;
    logic              dval;
    logic              ser_data, ser_val, busy;

    serializer #(.DATA_W(DATA_W), .MOD_W(MOD_W)) dut (
        .clk_i          (clk),
        .srst_i         (srst),
        .data_i         (din),
        .data_mod_i     (dmod),
        .data_val_i     (dval),
        .ser_data_o     (ser_data),
        .ser_data_val_o (ser_val),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic bitv;
        logic last;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   free_at = 0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    bit   mon_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Monitor: one expected entry per valid output cycle, tagged with its cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                chk("ser_val", {31'd0, ser_val}, 32'd1);
                chk("ser_data", {31'd0, ser_data}, {31'd0, q[0].bitv});
                chk("busy", {31'd0, busy}, {31'd0, ~q[0].last});
                void'(q.pop_front());
            end else begin
                chk("idle_val", {31'd0, ser_val}, 32'd0);
                chk("idle_data", {31'd0, ser_data}, 32'd0);
                chk("idle_busy", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Reference: a word presented in cycle k is taken if the line is free by k,
    // its bits occupy cycles k+1..k+N, and the line frees again at cycle k+N.
    task automatic step(input logic v, input logic [DATA_W-1:0] d,
                        input logic [MOD_W-1:0] m, input logic r);
        int   k;
        int   n;
        exp_t e;
        k    = cyc;
        srst = r;
        dval = v;
        din  = d;
        dmod = m;
        n    = (m == 0) ? DATA_W : int'(m);
        if (r) begin
            while (q.size() > 0 && q[q.size()-1].cyc > k) void'(q.pop_back());
            free_at = k + 1;
        end else if (v && k >= free_at && n >= 3) begin
            for (int i = 0; i < n; i++) begin
                e.cyc = k + 1 + i;
`ifdef SERIALIZER_LSB_FIRST_EN
                e.bitv = d[i];
`else
                e.bitv = d[DATA_W-1-i];
`endif
                e.last = (i == n - 1);
                q.push_back(e);
            end
            free_at = k + n;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        srst = 1'b1;
        dval = 1'b0;
        din  = '0;
        dmod = '0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        step(1'b0, '0, '0, 1'b1);

        step(1'b1, 16'hA5C3, 4'd0, 1'b0);
        idle(18);

        step(1'b1, 16'hF000, 4'd5, 1'b0);
        idle(7);

        step(1'b1, 16'hFFFF, 4'd1, 1'b0);
        step(1'b1, 16'hFFFF, 4'd2, 1'b0);
        idle(3);

        // second word lands exactly in the first word's last-bit cycle
        step(1'b1, 16'hFFFF, 4'd3, 1'b0);
        idle(2);
        step(1'b1, 16'h0000, 4'd4, 1'b0);
        idle(6);

        step(1'b1, 16'h8001, 4'd0, 1'b0);
        idle(3);
        step(1'b1, 16'h7E7E, 4'd6, 1'b0);
        idle(16);

        step(1'b1, 16'hBEEF, 4'd0, 1'b0);
        idle(5);
        step(1'b1, 16'h1234, 4'd0, 1'b1);
        step(1'b1, 16'hC0DE, 4'd7, 1'b0);
        idle(10);

        for (int i = 0; i < 800; i++) begin
            step(1'b1 & ($urandom_range(0, 2) != 0), 16'($urandom),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 59) == 0));
        end
        idle(20);

        chk("drain_empty", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
